// File: rtl/fpu_normalize.sv
`default_nettype none
// ============================================================================
// Module      : fpu_normalize
// Description : Bit-serial post-arithmetic normalizer for fpu results. It packs
//               each result into {exp[7:0], mant[23:0]} behind a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_normalize #(
    parameter int MAX_SHIFT = 47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  opcode,
    input  logic [55:0] result,
    input  logic        ovf_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        ovf_flag,
    output logic        unf_flag,
    output logic        zero_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] c_max_shift = 6'(MAX_SHIFT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [47:0]        r_mant;
    logic [7:0]         r_exp;
    logic [5:0]         r_shift;
    logic               r_ovf_in;
    logic               w_term;
    logic signed [9:0]  w_exp_adj;
    logic [31:0]        w_word;
    logic               w_ovf;
    logic               w_unf;
    logic               w_zero;
    logic [47:0]        w_cap_mant;
    logic [7:0]         w_cap_exp;
    logic               w_unused_opcode_lsb;

    // Only opcode[1] separates multiply from add/sub.
    assign w_unused_opcode_lsb = opcode[0];
    assign in_ready = (r_state == ST_IDLE);

    assign w_cap_exp  = opcode[1] ? result[55:48] : result[31:24];
    assign w_cap_mant = opcode[1] ? result[47:0]  : {{24{result[23]}}, result[23:0]};

    assign w_term    = (r_mant == 48'd0) || (r_mant[47] != r_mant[46]) || (r_shift == c_max_shift);
    assign w_exp_adj = $signed({2'b00, r_exp}) + 10'sd24 - $signed({4'b0000, r_shift});

    always_comb begin
        w_word = 32'd0;
        w_ovf  = r_ovf_in;
        w_unf  = 1'b0;
        w_zero = 1'b0;
        if (r_mant == 48'd0) begin
            w_zero = 1'b1;
        end else if (w_exp_adj < 10'sd0) begin
            w_unf = 1'b1;
        end else if (w_exp_adj > 10'sd255) begin
            w_ovf  = 1'b1;
            w_word = r_mant[47] ? 32'hFF800000 : 32'hFF7FFFFF;
        end else begin
            w_word = {w_exp_adj[7:0], r_mant[47:24]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_term)    w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mant    <= 48'd0;
            r_exp     <= 8'd0;
            r_shift   <= 6'd0;
            r_ovf_in  <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            ovf_flag  <= 1'b0;
            unf_flag  <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mant   <= w_cap_mant;
                        r_exp    <= w_cap_exp;
                        r_shift  <= 6'd0;
                        r_ovf_in <= ovf_in;
                    end
                end
                ST_SHIFT: begin
                    if (w_term) begin
                        out_word  <= w_word;
                        ovf_flag  <= w_ovf;
                        unf_flag  <= w_unf;
                        zero_flag <= w_zero;
                        out_valid <= 1'b1;
                    end else begin
                        r_mant  <= {r_mant[46:0], 1'b0};
                        r_shift <= r_shift + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_normalize.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_normalize
// Description : Randomized and directed bench for fpu_normalize.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  opcode;
    logic [55:0] result;
    logic        ovf_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        ovf_flag;
    logic        unf_flag;
    logic        zero_flag;

    int r_total = 0;
    int r_bad   = 0;

    fpu_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .result    (result),
        .ovf_in    (ovf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .ovf_flag  (ovf_flag),
        .unf_flag  (unf_flag),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_total++;
        if (obs !== exp) begin
            r_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Reference: treat the mantissa as a signed integer, double it until it
    // leaves [-2^46, 2^46) or the shift limit is hit, then apply the range rules.
    task automatic ref_model(input logic [1:0] op, input logic [55:0] res, input logic ovf,
                             output logic [31:0] word, output logic [2:0] flags, output int s);
        longint m;
        int     e;
        int     big_e;
        logic [63:0] q;
        if (op[1]) begin
            e = int'(res[55:48]);
            m = longint'($signed(res[47:0]));
        end else begin
            e = int'(res[31:24]);
            m = longint'($signed(res[23:0]));
        end
        s = 0;
        while (m != 0 && m >= -(64'sd1 <<< 46) && m < (64'sd1 <<< 46) && s < 47) begin
            m = m * 2;
            s++;
        end
        big_e = e + 24 - s;
        word  = 32'd0;
        flags = {ovf, 2'b00};          // {ovf, unf, zero}
        if (m == 0) begin
            flags[0] = 1'b1;
        end else if (big_e < 0) begin
            flags[1] = 1'b1;
        end else if (big_e > 255) begin
            flags[2] = 1'b1;
            word = (m < 0) ? 32'hFF800000 : 32'hFF7FFFFF;
        end else begin
            q = 64'(m / (64'sd1 <<< 24) - ((m < 0 && (m % (64'sd1 <<< 24)) != 0) ? 1 : 0));
            word = {8'(big_e), q[23:0]};
        end
    endtask

    task automatic run_one(input string tag, input logic [1:0] op, input logic [55:0] res,
                           input logic ovf, input int hold);
        logic [31:0] e_word;
        logic [2:0]  e_flags;
        int          e_s;
        int          lat;
        logic [31:0] held;
        ref_model(op, res, ovf, e_word, e_flags, e_s);
        @(negedge clk);
        opcode   = op;
        result   = res;
        ovf_in   = ovf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        result   = {24'($urandom), 32'($urandom)};
        opcode   = 2'($urandom);
        ovf_in   = 1'($urandom);
        lat = 1;
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(e_s + 2));
        chk({tag, "_word"}, 64'(out_word), 64'(e_word));
        chk({tag, "_flags"}, 64'({ovf_flag, unf_flag, zero_flag}), 64'(e_flags));
        held = out_word;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, 64'({out_valid, in_ready, out_word}), 64'({2'b10, held}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_hs"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 2'b00;
        result    = 56'd0;
        ovf_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({in_ready, out_valid, out_word, ovf_flag, unf_flag, zero_flag}),
            64'({2'b10, 32'd0, 3'b000}));
        reset = 1'b1;

        run_one("add_norm",  2'b00, {24'h0, 32'h04400000}, 1'b0, 0);
        run_one("add_small", 2'b01, {24'h0, 32'h40000004}, 1'b0, 0);
        run_one("mul",       2'b10, {8'h02, 48'h100000000000}, 1'b0, 0);
        run_one("zero",      2'b10, {8'h33, 48'h0}, 1'b1, 0);
        run_one("ovf",       2'b11, {8'hF0, 48'h400000000000}, 1'b0, 0);
        run_one("unf",       2'b00, {24'h0, 32'h04000004}, 1'b0, 0);
        run_one("minus_one", 2'b00, {24'h0, 32'h50FFFFFF}, 1'b0, 0);
        run_one("neg_ovf",   2'b10, {8'hFF, 48'h800000000000}, 1'b0, 0);
        run_one("backpress", 2'b00, {24'h0, 32'h10000100}, 1'b1, 5);

        for (int n = 0; n < 40; n++) begin
            logic [55:0] r;
            logic [1:0]  op;
            op = 2'($urandom);
            r  = {24'($urandom), 32'($urandom)};
            if (op[1]) r[47:0] = $signed(r[47:0]) >>> $urandom_range(47, 0);
            else       r[23:0] = $signed(r[23:0]) >>> $urandom_range(23, 0);
            run_one("rand", op, r, 1'($urandom), int'($urandom_range(2, 0)));
        end

        // Reset in the middle of a long shift discards the pending work.
        @(negedge clk);
        opcode   = 2'b00;
        result   = {24'h0, 32'h40000004};
        ovf_in   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_reset", 64'({in_ready, out_valid, out_word, ovf_flag, unf_flag, zero_flag}),
            64'({2'b10, 32'd0, 3'b000}));
        run_one("post_reset", 2'b10, {8'h02, 48'h100000000000}, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_normalize.md
# fpu_normalize

Post-arithmetic normalizer that sits directly downstream of the `fpu` datapath. It accepts one raw 56-bit result with its opcode and overflow flag, then left-shifts the signed mantissa one bit per cycle until it is normalized. It adjusts the exponent, truncates to the 32-bit operand format {exp[7:0], mant[23:0]} and returns it through a valid/ready handshake. The output word can be fed straight back as `opA`/`opB`.

## Interface
- `MAX_SHIFT`, default 47: shift-count ceiling; fixed by the 48-bit mantissa and not to be overridden.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  raw result present.
- `in_ready`  out  1  block idle and able to accept a result.
- `opcode`  in  2  opcode that produced `result`: 00 add, 01 sub, 10/11 multiply.
- `result`  in  56  raw `fpu` result.
- `ovf_in`  in  1  `fpu` overflow flag, captured with `result`.
- `out_valid`  out  1  normalized word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_word`  out  32  {exp[7:0] unsigned, mant[23:0] two's complement}.
- `ovf_flag`  out  1  `ovf_in` OR exponent overflow.
- `unf_flag`  out  1  exponent underflow.
- `zero_flag`  out  1  result is zero.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`, capture the inputs, set shift count s = 0 and go to SHIFT.
- **Decode at capture:**
  - Opcode 00/01: e = `result[31:24]`; m = `result[23:0]` sign-extended to 48 bits.
  - Opcode 10/11: e = `result[55:48]`; m = `result[47:0]`.
- **SHIFT (evaluated once per cycle):**
  - Terminate if m == 0, or m[47] != m[46], or s == 47; next state is DONE with the output registered.
  - Otherwise m <<= 1, s += 1, stay in SHIFT.
- **Exponent arithmetic:** computed in 10-bit signed: E = e + 24 − s.
- **Output selection, first match wins:**
  - m == 0: `out_word` = 0, `zero_flag` = 1.
  - E < 0: `out_word` = 0, `unf_flag` = 1.
  - E > 255: exp = 8'hFF; mant = 24'h7FFFFF if m[47] == 0, else 24'h800000; `ovf_flag` = 1.
  - Otherwise: exp = E[7:0]; mant = m[47:24], truncated with no rounding.
- **Flag handling:** `ovf_flag` always includes `ovf_in`.
- **All-ones mantissa (−1):** reaches s = 47 and yields mant = 24'h800000 with E = e − 23.
- **DONE:**
  - `out_valid` = 1; `out_word` and the flags are held stable.
  - On `out_ready`, return to IDLE and drop `out_valid`.
  - `in_ready` = 0 throughout DONE.

## Timing
- **Reset:** `reset` low at a clock edge forces IDLE on the next cycle.
  - Outputs after reset: `in_ready` = 1, `out_valid` = 0, `out_word` = 0, all flags 0.
  - Applies from any state, including mid-SHIFT and in DONE with a pending word, which is discarded.
- **Latency:** acceptance at edge 0 gives `out_valid` high at cycle s + 2. Minimum 2 cycles, maximum 49.
- **No overlap:** `in_ready` is low from the cycle after acceptance until the cycle after the output handshake. Throughput is one result per s + 3 cycles with `out_ready` held high.
- **Outputs:** all registered; nothing combinational from inputs to outputs except none.
- **Input stability:** `result`, `opcode` and `ovf_in` need only be stable in the acceptance cycle.
- **Simultaneous events:** `in_valid` during DONE is ignored; the producer must hold it.

## Test plan
- **Add result already normalized:** opcode 00, `result[31:0]` = 32'h04400000 → `out_word` = 32'h04400000, flags 0, s = 24, `out_valid` at cycle 26.
- **Add result, small mantissa:** opcode 00, `result[31:0]` = 32'h40000004 → s = 44, `out_word` = 32'h2C400000, `out_valid` at cycle 46.
- **Multiply:** opcode 10, `result` = {8'h02, 48'h100000000000} → s = 2, `out_word` = 32'h18400000, latency 4.
- **Zero:** opcode 10, mantissa 0, exponent 8'h33, `ovf_in` = 1 → `out_word` = 0, `zero_flag` = 1, `ovf_flag` = 1, latency 2.
- **Overflow and underflow:**
  - Opcode 10, {8'hF0, 48'h400000000000} → `out_word` = 32'hFF7FFFFF, `ovf_flag` = 1.
  - Opcode 00, 32'h04000004 → E = −16, so `out_word` = 0 and `unf_flag` = 1.
- **Backpressure and reset:**
  - Hold `out_ready` = 0 for 5 cycles in DONE: `out_word` stable, `in_ready` = 0.
  - Drive `reset` = 0 for one edge mid-SHIFT: next cycle IDLE, `out_valid` = 0, `in_ready` = 1, flags 0.
